rb_mod_stream_feeder: RTL and testbench
=======================================

RB_MOD_STREAM_FEEDER -- requirements
Module: rb_mod_stream_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 4, giving FIFO depth 2^DEPTH_LOG2 entries.
REQ-002 The block SHALL have parameter PRIME_LVL, default 8, giving the fill level required before streaming starts or resumes.
REQ-003 Port clk_adc_125mhz, input, 1 bit: the single clock, 125 MHz ADC based.
REQ-004 Port adc_rstn_i, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port en_i, input, 1 bit: feeder enable, driven from the RB_CTRL OSC1_INC_SRC_STREAM bit.
REQ-006 Port rate_div_i, input, 16 bits: output sample period minus one, in clk cycles.
REQ-007 Port clr_i, input, 1 bit: one-cycle pulse that clears the sticky flags and the underrun counter.
REQ-008 Port wr_vld_i, input, 1 bit: write sample valid.
REQ-009 Port wr_dat_i, input, 48 bits: OSC1 phase increment sample.
REQ-010 Port wr_rdy_o, output, 1 bit: FIFO can accept a sample.
REQ-011 Port inc_o, output, 48 bits: held increment, feeding osc1_inc_stream.
REQ-012 Port inc_vld_o, output, 1 bit: one-cycle pulse when inc_o updates.
REQ-013 Port fill_o, output, DEPTH_LOG2+1 bits: current FIFO fill level.
REQ-014 Port state_o, output, 2 bits: current FSM state.
REQ-015 Port underrun_o, output, 1 bit: sticky underrun flag.
REQ-016 Port overrun_o, output, 1 bit: sticky flag, set on a write attempt while full.
REQ-017 Port urun_cnt_o, output, 16 bits: saturating underrun count.

Function
REQ-018 A write SHALL occur when wr_vld_i && wr_rdy_o; wr_rdy_o = (fill < 2^DEPTH_LOG2) && en_i.
REQ-019 wr_vld_i while full and en_i high SHALL drop the sample and set overrun_o.
REQ-020 FSM states SHALL be IDLE=0, PRIME=1, RUN=2, URUN=3.
REQ-021 FSM transitions:
- any state with en_i=0 -> IDLE
- IDLE with en_i=1 -> PRIME
- PRIME with fill >= PRIME_LVL -> RUN
- RUN, on a tick with fill=0 -> URUN
- URUN with fill >= PRIME_LVL -> RUN
REQ-022 Pacing counter behaviour:
- cleared on entry to RUN
- counts 0..rate_div_i in RUN
- tick when count == rate_div_i, then wraps to 0
- rate_div_i=0 gives a tick every cycle
- rate_div_i changes take effect at the next wrap
REQ-023 On a RUN tick with fill > 0, one entry SHALL be popped; inc_o takes it and inc_vld_o pulses one cycle later (latency 1).
REQ-024 On a RUN tick with fill = 0:
- inc_o SHALL hold its last value
- underrun_o SHALL be set
- urun_cnt_o SHALL increment, saturating at 16'hFFFF
REQ-025 A push and a pop in the same cycle SHALL leave fill unchanged; FIFO pointers wrap modulo depth.
REQ-026 en_i falling SHALL flush the FIFO (fill=0) and zero inc_o on the next cycle.
REQ-027 clr_i SHALL clear underrun_o, overrun_o and urun_cnt_o; if clr_i coincides with a set event, the set event wins.
REQ-028 Stored and output data SHALL be 48 bits unmodified; no arithmetic is applied to samples.

Reset
REQ-029 When adc_rstn_i=0 at a clock edge, the block SHALL enter this state:
- state IDLE
- FIFO empty, fill_o=0
- inc_o=0, inc_vld_o=0, wr_rdy_o=0
- underrun_o=0, overrun_o=0, urun_cnt_o=0
- pacing counter 0
REQ-030 Reset asserted mid-stream SHALL discard all FIFO contents; no sample is emitted after reset.

Structure
REQ-031 The state enum, the 48-bit increment width constant and the default DEPTH_LOG2 SHALL live in the shared package rb_pkg.
REQ-032 FIFO storage and pointers SHALL be a sub-module rb_sync_fifo (width, depth parameters; synchronous, first-word-fall-through); FSM, pacing and flags stay in rb_mod_stream_feeder.

Verification
REQ-033 Prime and run:
- stimulus: en_i=1, rate_div_i=3, write 8 samples 1..8
- response: PRIME -> RUN; inc_o = 1,2,...,8 with inc_vld_o pulses exactly 4 cycles apart
REQ-034 Underrun:
- stimulus: after the 8 samples drain, no further writes
- response: next tick -> URUN, underrun_o=1, urun_cnt_o=1, inc_o holds 8
- then write 8 samples -> back to RUN
REQ-035 Overrun:
- stimulus: en_i=1, rate_div_i=16'hFFFF, write 17 samples back-to-back
- response: wr_rdy_o=0 after the 16th, fill_o=16, overrun_o=1, 17th sample absent from the output
REQ-036 Simultaneous push/pop:
- stimulus: rate_div_i=0 in RUN, one write per cycle
- response: fill_o constant, samples emitted in order with no gaps
REQ-037 Disable and reset mid-stream:
- en_i low mid-stream -> IDLE, fill_o=0, inc_o=0 next cycle
- adc_rstn_i low mid-stream -> all outputs at reset values
- clr_i coinciding with an underrun tick -> underrun_o stays 1

Source files
------------

// File: rtl/rb_pkg.sv
// Shared types and constants for the RB stream feeder: state encoding,
// increment sample width and default FIFO depth.
package rb_pkg;

  localparam int INC_W          = 48;
  localparam int DEPTH_LOG2_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_URUN  = 2'd3
  } feed_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rb_sync_fifo.sv
// Synchronous first-word-fall-through FIFO: dat_o shows the head entry with zero latency.
// Pushes while full and pops while empty are ignored; flush_i empties it in one cycle.
module rb_sync_fifo #(
  parameter int WIDTH      = 48,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      dat_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      dat_o,
  output logic [DEPTH_LOG2:0]   fill_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_FILL = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   fill_q;
  logic                  push_ok, pop_ok;

  assign full_o  = (fill_q == DEPTH_FILL);
  assign empty_o = (fill_q == '0);
  assign fill_o  = fill_q;
  assign dat_o   = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers are exactly DEPTH_LOG2 bits wide, so they wrap modulo depth for free.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i && !flush_i && push_ok) mem_q[wr_ptr_q] <= dat_i;
  end

endmodule

// File: rtl/rb_mod_stream_feeder.sv
// Paces buffered OSC1 increment samples out at one per (rate_div_i+1) cycles, 1-cycle pop-to-output latency.
// Writers are backpressured by wr_rdy_o when full or disabled; an empty FIFO at a tick is an underrun.
module rb_mod_stream_feeder
  import rb_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int PRIME_LVL  = 8
) (
  input  logic                  clk_adc_125mhz,
  input  logic                  adc_rstn_i,
  input  logic                  en_i,
  input  logic [15:0]           rate_div_i,
  input  logic                  clr_i,
  input  logic                  wr_vld_i,
  input  logic [INC_W-1:0]      wr_dat_i,
  output logic                  wr_rdy_o,
  output logic [INC_W-1:0]      inc_o,
  output logic                  inc_vld_o,
  output logic [DEPTH_LOG2:0]   fill_o,
  output logic [1:0]            state_o,
  output logic                  underrun_o,
  output logic                  overrun_o,
  output logic [15:0]           urun_cnt_o
);

  localparam int FILL_W = DEPTH_LOG2 + 1;
  localparam logic [FILL_W-1:0] PRIME_FILL = FILL_W'(PRIME_LVL);

  feed_state_e        state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        rate_q, rate_d;
  logic [INC_W-1:0]   inc_q, inc_d;
  logic               inc_vld_q, inc_vld_d;
  logic               urun_q, urun_d;
  logic               ovr_q, ovr_d;
  logic [15:0]        urun_cnt_q, urun_cnt_d;

  logic [INC_W-1:0]   fifo_dat;
  logic [FILL_W-1:0]  fifo_fill;
  logic               fifo_full, fifo_empty;
  logic               push, pop, tick, urun_evt, ovr_evt, primed;

  assign wr_rdy_o = adc_rstn_i && en_i && !fifo_full;
  assign push     = wr_vld_i && wr_rdy_o;
  assign ovr_evt  = wr_vld_i && en_i && fifo_full;
  assign tick     = en_i && (state_q == ST_RUN) && (cnt_q == rate_q);
  assign pop      = tick && !fifo_empty;
  assign urun_evt = tick && fifo_empty;
  assign primed   = (fifo_fill >= PRIME_FILL);

  rb_sync_fifo #(
    .WIDTH      (INC_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk_adc_125mhz),
    .rstn_i  (adc_rstn_i),
    .flush_i (!en_i),
    .push_i  (push),
    .dat_i   (wr_dat_i),
    .pop_i   (pop),
    .dat_o   (fifo_dat),
    .fill_o  (fifo_fill),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_PRIME;
        ST_PRIME: if (primed) state_d = ST_RUN;
        ST_RUN:   if (urun_evt) state_d = ST_URUN;
        ST_URUN:  if (primed) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // The divider is sampled only at RUN entry and at each wrap so a period is never cut short.
  always_comb begin
    cnt_d  = cnt_q;
    rate_d = rate_q;
    if (state_d == ST_RUN && state_q != ST_RUN) begin
      cnt_d  = '0;
      rate_d = rate_div_i;
    end else if (state_q == ST_RUN && en_i) begin
      if (tick) begin
        cnt_d  = '0;
        rate_d = rate_div_i;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else if (state_d == ST_IDLE) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    inc_d     = inc_q;
    inc_vld_d = 1'b0;
    if (!en_i) begin
      inc_d = '0;
    end else if (pop) begin
      inc_d     = fifo_dat;
      inc_vld_d = 1'b1;
    end
  end

  // A set event in the same cycle as clr_i wins; the counter restarts from the clear.
  always_comb begin
    urun_d     = clr_i ? 1'b0 : urun_q;
    ovr_d      = clr_i ? 1'b0 : ovr_q;
    urun_cnt_d = clr_i ? 16'd0 : urun_cnt_q;
    if (urun_evt) begin
      urun_d     = 1'b1;
      urun_cnt_d = sat_inc16(urun_cnt_d);
    end
    if (ovr_evt) ovr_d = 1'b1;
  end

  always_ff @(posedge clk_adc_125mhz) begin
    if (!adc_rstn_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rate_q     <= '0;
      inc_q      <= '0;
      inc_vld_q  <= 1'b0;
      urun_q     <= 1'b0;
      ovr_q      <= 1'b0;
      urun_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rate_q     <= rate_d;
      inc_q      <= inc_d;
      inc_vld_q  <= inc_vld_d;
      urun_q     <= urun_d;
      ovr_q      <= ovr_d;
      urun_cnt_q <= urun_cnt_d;
    end
  end

  assign inc_o      = inc_q;
  assign inc_vld_o  = inc_vld_q;
  assign fill_o     = fifo_fill;
  assign state_o    = state_q;
  assign underrun_o = urun_q;
  assign overrun_o  = ovr_q;
  assign urun_cnt_o = urun_cnt_q;

endmodule

// File: tb/tb_rb_mod_stream_feeder.sv
// Scoreboard bench for rb_mod_stream_feeder: writes push expected samples, a monitor
// pops and compares on every inc_vld_o pulse.
module tb_rb_mod_stream_feeder;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        en_i;
  logic [15:0] rate_div_i;
  logic        clr_i;
  logic        wr_vld_i;
  logic [47:0] wr_dat_i;
  logic        wr_rdy_o;
  logic [47:0] inc_o;
  logic        inc_vld_o;
  logic [4:0]  fill_o;
  logic [1:0]  state_o;
  logic        underrun_o;
  logic        overrun_o;
  logic [15:0] urun_cnt_o;

  always #4 clk = ~clk;

  rb_mod_stream_feeder dut (
    .clk_adc_125mhz (clk),
    .adc_rstn_i     (rstn_i),
    .en_i           (en_i),
    .rate_div_i     (rate_div_i),
    .clr_i          (clr_i),
    .wr_vld_i       (wr_vld_i),
    .wr_dat_i       (wr_dat_i),
    .wr_rdy_o       (wr_rdy_o),
    .inc_o          (inc_o),
    .inc_vld_o      (inc_vld_o),
    .fill_o         (fill_o),
    .state_o        (state_o),
    .underrun_o     (underrun_o),
    .overrun_o      (overrun_o),
    .urun_cnt_o     (urun_cnt_o)
  );

  logic [47:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int last_vld = -1;
  int exp_gap = 1;
  bit gap_chk = 1'b0;

  // Monitor: compare every emitted sample against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (inc_vld_o) begin
        vld_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sample got %0h expected none", inc_o);
        end else begin
          logic [47:0] e;
          e = exp_q.pop_front();
          if (inc_o !== e) begin
            errors++;
            $display("FAIL sample_data got %0h expected %0h", inc_o, e);
          end
        end
        if (gap_chk) begin
          if (last_vld >= 0) begin
            checks++;
            if (cyc - last_vld != exp_gap) begin
              errors++;
              $display("FAIL vld_spacing got %0d expected %0d", cyc - last_vld, exp_gap);
            end
          end
          last_vld = cyc;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog_timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [47:0] d, output bit acc);
    wr_vld_i = 1'b1;
    wr_dat_i = d;
    acc = wr_rdy_o;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    wr_vld_i = 1'b0;
  endtask

  task automatic wr_block(input int base, input int n);
    bit acc;
    for (int i = 0; i < n; i++) wr(48'(base + i), acc);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
    int n = 0;
    while (state_o !== s && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, 64'(state_o), 64'(s));
  endtask

  task automatic wait_vld(input int target, input int budget, input string nm);
    int n = 0;
    while (vld_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, 64'(vld_cnt >= target), 64'd1);
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    bit acc17;
    int n;
    rstn_i = 1'b0; en_i = 1'b0; rate_div_i = 16'd3; clr_i = 1'b0;
    wr_vld_i = 1'b0; wr_dat_i = '0;
    step(3);
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_fill", 64'(fill_o), 64'd0);
    chk("rst_inc", 64'(inc_o), 64'd0);
    chk("rst_vld", 64'(inc_vld_o), 64'd0);
    chk("rst_rdy", 64'(wr_rdy_o), 64'd0);
    chk("rst_flags", 64'({underrun_o, overrun_o}), 64'd0);
    chk("rst_ucnt", 64'(urun_cnt_o), 64'd0);
    rstn_i = 1'b1;
    step(1);

    // Prime and run at rate_div 3: samples 1..8, four cycles apart.
    en_i = 1'b1;
    step(1);
    chk("prime_state", 64'(state_o), 64'd1);
    gap_chk = 1'b1; exp_gap = 4; last_vld = -1;
    wr_block(1, 8);
    wait_state(2'd2, 5, "enter_run");
    wait_vld(8, 60, "drain_8");
    gap_chk = 1'b0;

    // Underrun after drain, then refill.
    wait_state(2'd3, 10, "enter_urun");
    chk("urun_flag", 64'(underrun_o), 64'd1);
    chk("urun_cnt1", 64'(urun_cnt_o), 64'd1);
    chk("urun_hold", 64'(inc_o), 64'd8);
    wr_block(100, 8);
    wait_state(2'd2, 5, "resume_run");
    wait_state(2'd3, 60, "urun_again");
    chk("urun_cnt2", 64'(urun_cnt_o), 64'd2);
    chk("urun_hold2", 64'(inc_o), 64'd107);

    // Clear, then clear coinciding with an underrun tick.
    clr_i = 1'b1; step(1); clr_i = 1'b0;
    chk("clr_flags", 64'({underrun_o, overrun_o}), 64'd0);
    chk("clr_cnt", 64'(urun_cnt_o), 64'd0);
    rate_div_i = 16'd0;
    wr_block(200, 8);
    n = 0;
    while (!(state_o == 2'd2 && fill_o == 5'd0) && n < 40) begin
      step(1);
      n++;
    end
    chk("pre_urun_tick", 64'(state_o == 2'd2 && fill_o == 5'd0), 64'd1);
    clr_i = 1'b1; step(1); clr_i = 1'b0;
    chk("clr_vs_set", 64'(underrun_o), 64'd1);
    chk("clr_vs_set_st", 64'(state_o), 64'd3);

    // Disable mid-stream.
    rate_div_i = 16'd3;
    wr_block(300, 8);
    wait_state(2'd2, 5, "dis_run");
    wait_vld(vld_cnt + 2, 30, "dis_some_out");
    en_i = 1'b0;
    step(1);
    chk("dis_state", 64'(state_o), 64'd0);
    chk("dis_fill", 64'(fill_o), 64'd0);
    chk("dis_inc", 64'(inc_o), 64'd0);
    chk("dis_rdy", 64'(wr_rdy_o), 64'd0);
    exp_q.delete();
    step(10);

    // Overrun: 17 back-to-back writes into a 16-deep FIFO.
    en_i = 1'b1;
    rate_div_i = 16'hFFFF;
    step(1);
    chk("ovr_prime", 64'(state_o), 64'd1);
    acc17 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr(48'(400 + i), acc);
      if (i == 16) acc17 = acc;
    end
    chk("ovr_acc17", 64'(acc17), 64'd0);
    chk("ovr_rdy", 64'(wr_rdy_o), 64'd0);
    chk("ovr_fill", 64'(fill_o), 64'd16);
    chk("ovr_flag", 64'(overrun_o), 64'd1);
    chk("ovr_queued", 64'(exp_q.size()), 64'd16);
    rate_div_i = 16'd0;
    wait_drain(70000, "ovr_drain");
    step(3);
    chk("ovr_after", 64'(state_o), 64'd3);

    // Simultaneous push/pop at rate_div 0.
    gap_chk = 1'b1; exp_gap = 1; last_vld = -1;
    for (int i = 0; i < 30; i++) begin
      wr(48'(500 + i), acc);
      if (i >= 10 && (i % 4) == 2) chk("pushpop_fill", 64'(fill_o), 64'd9);
    end
    wait_drain(30, "pushpop_drain");
    step(2);
    gap_chk = 1'b0;

    // Reset mid-stream.
    rate_div_i = 16'd3;
    wr_block(600, 8);
    wait_state(2'd2, 5, "rst_run");
    wait_vld(vld_cnt + 1, 30, "rst_some_out");
    rstn_i = 1'b0;
    step(1);
    chk("mrst_state", 64'(state_o), 64'd0);
    chk("mrst_fill", 64'(fill_o), 64'd0);
    chk("mrst_inc", 64'(inc_o), 64'd0);
    chk("mrst_out", 64'({inc_vld_o, wr_rdy_o}), 64'd0);
    chk("mrst_flags", 64'({underrun_o, overrun_o}), 64'd0);
    chk("mrst_ucnt", 64'(urun_cnt_o), 64'd0);
    exp_q.delete();
    step(2);
    rstn_i = 1'b1;
    step(30);
    chk("post_rst_state", 64'(state_o), 64'd1);
    chk("post_rst_fill", 64'(fill_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
